// File: rtl/pipeline_seq_pkg.sv
// rtl/pipeline_seq_pkg.sv - shared state encoding and decode constants for the pipeline sequencer
package pipeline_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_RUN    = 2'd0,
        SEQ_DRAIN  = 2'd1,
        SEQ_HALTED = 2'd2
    } seq_state_t;

    localparam int REG_ADDR_W = 5;

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_HALT = 7'b1111111;

endpackage

// File: rtl/pipeline_sequencer_sat_counter.sv
// rtl/pipeline_sequencer_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - stall/flush/freeze sequencing for the 5-stage pipeline
// Optional perf counters built only when PIPELINE_SEQ_PERF_EN is defined.
module pipeline_sequencer
    import pipeline_seq_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  halt_id,
    input  logic                  idex_memread,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic [REG_ADDR_W-1:0] ifid_rs1,
    input  logic [REG_ADDR_W-1:0] ifid_rs2,
    input  logic                  branch_taken_ex,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_hold,
    output logic                  halted,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [DW-1:0] DRAIN_INIT = (DRAIN_CYCLES > 0) ? DW'(DRAIN_CYCLES - 1) : '0;
    localparam logic [WW-1:0] WAIT_LAST  = (MEM_TIMEOUT > 0) ? WW'(MEM_TIMEOUT - 1) : '0;

    seq_state_t    state;
    logic [DW-1:0] drain_cnt;
    logic [WW-1:0] wait_cnt;
    logic          err_q;

    logic mem_wait;
    logic load_use;
    logic timeout_hit;

    assign mem_wait    = mem_req && !mem_ready;
    assign load_use    = idex_memread && (idex_rd != '0) &&
                         ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
    assign timeout_hit = (MEM_TIMEOUT != 0) && mem_wait && (wait_cnt == WAIT_LAST);

    // Mealy controls; every output is forced low while reset is held.
    always_comb begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        exmem_hold = 1'b0;
        halted     = 1'b0;
        if (reset_n) begin
            case (state)
                SEQ_HALTED: begin
                    halted     = 1'b1;
                    exmem_hold = 1'b1;
                end
                default: begin
                    if (mem_wait) begin
                        exmem_hold = 1'b1;
                    end else if (branch_taken_ex) begin
                        pc_write   = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use || (state == SEQ_DRAIN) || halt_id) begin
                        idex_flush = 1'b1;
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                    end
                end
            endcase
        end
    end

    assign mem_err = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SEQ_RUN;
            drain_cnt <= '0;
            wait_cnt  <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                SEQ_HALTED: begin
                    wait_cnt <= '0;
                end
                default: begin
                    if (mem_wait) begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (timeout_hit) begin
                            err_q <= 1'b1;
                            state <= SEQ_HALTED;
                        end
                    end else begin
                        wait_cnt <= '0;
                        if (state == SEQ_DRAIN) begin
                            if (drain_cnt == '0) begin
                                state <= SEQ_HALTED;
                            end else begin
                                drain_cnt <= drain_cnt - 1'b1;
                            end
                        end else if (!branch_taken_ex && !load_use && halt_id) begin
                            // A zero-length drain skips straight to the frozen state.
                            state     <= (DRAIN_CYCLES == 0) ? SEQ_HALTED : SEQ_DRAIN;
                            drain_cnt <= DRAIN_INIT;
                        end
                    end
                end
            endcase
        end
    end

`ifdef PIPELINE_SEQ_PERF_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = (state != SEQ_HALTED) && !pc_write;
    assign flush_inc = (state != SEQ_HALTED) && !mem_wait && branch_taken_ex;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (1'b0),
        .inc     (stall_inc),
        .count   (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (1'b0),
        .inc     (flush_inc),
        .count   (flush_events)
    );
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - randomized and directed checks of pipeline_sequencer against a behavioural model
module tb_pipeline_sequencer;

    localparam int DRAIN = 3;
    localparam int TMO   = 16;
    localparam int CW    = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          halt_id = 1'b0;
    logic          idex_memread = 1'b0;
    logic [4:0]    idex_rd = '0;
    logic [4:0]    ifid_rs1 = '0;
    logic [4:0]    ifid_rs2 = '0;
    logic          branch_taken_ex = 1'b0;
    logic          mem_req = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold, halted, mem_err;
    logic [CW-1:0] stall_cycles, flush_events;

    pipeline_sequencer #(.DRAIN_CYCLES(DRAIN), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .halt_id         (halt_id),
        .idex_memread    (idex_memread),
        .idex_rd         (idex_rd),
        .ifid_rs1        (ifid_rs1),
        .ifid_rs2        (ifid_rs2),
        .branch_taken_ex (branch_taken_ex),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_hold      (exmem_hold),
        .halted          (halted),
        .mem_err         (mem_err),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: "stopped" pipeline flag, remaining drain cycles, consecutive wait count.
    bit         m_stopped, m_draining, m_err;
    int         m_left, m_waits;
    longint     m_stall, m_flush;
    logic [6:0] e_out;
    bit         e_fire;

    function automatic logic [6:0] outs();
        return {pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold, halted, mem_err};
    endfunction

    function automatic logic [63:0] cnt_exp();
`ifdef PIPELINE_SEQ_PERF_EN
        return {m_stall[31:0], m_flush[31:0]};
`else
        return 64'd0;
`endif
    endfunction

    task automatic model_clear();
        m_stopped = 0; m_draining = 0; m_err = 0;
        m_left = 0; m_waits = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic predict();
        bit wt, lu;
        bit pw, iw, ifl, idf, hold;
        wt = mem_req && !mem_ready;
        lu = idex_memread && idex_rd != 0 && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
        {pw, iw, ifl, idf, hold} = '0;
        e_fire = 0;
        if (m_stopped) hold = 1;
        else if (wt) hold = 1;
        else if (branch_taken_ex) begin pw = 1; ifl = 1; idf = 1; e_fire = 1; end
        else if (lu || m_draining || halt_id) idf = 1;
        else begin pw = 1; iw = 1; end
        e_out = {pw, iw, ifl, idf, hold, m_stopped, m_err};
    endtask

    task automatic advance();
        bit wt, lu;
        if (m_stopped) return;
        if (!e_out[6]) m_stall++;
        if (e_fire) m_flush++;
        wt = mem_req && !mem_ready;
        lu = idex_memread && idex_rd != 0 && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
        if (wt) begin
            m_waits++;
            if (m_waits == TMO) begin m_err = 1; m_stopped = 1; end
        end else begin
            m_waits = 0;
            if (m_draining) begin
                m_left--;
                if (m_left == 0) m_stopped = 1;
            end else if (halt_id && !branch_taken_ex && !lu) begin
                m_draining = 1;
                m_left = DRAIN;
            end
        end
    endtask

    task automatic step(input string tag, input logic h, input logic mr, input logic [4:0] rd,
                        input logic [4:0] r1, input logic [4:0] r2, input logic br,
                        input logic mq, input logic mrdy);
        halt_id = h; idex_memread = mr; idex_rd = rd; ifid_rs1 = r1; ifid_rs2 = r2;
        branch_taken_ex = br; mem_req = mq; mem_ready = mrdy;
        @(negedge clk);
        predict();
        check(tag, 64'(outs()), 64'(e_out));
        check({tag, "_cnt"}, {stall_cycles, flush_events}, cnt_exp());
        @(posedge clk);
        #1;
        advance();
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Asserted a moment after a rising edge, so it lands mid-cycle.
    task automatic apply_reset(input string tag);
        branch_taken_ex = 1; halt_id = 1; mem_req = 1; mem_ready = 0;
        reset_n = 0;
        #1;
        check(tag, 64'(outs()), 64'd0);
        check({tag, "_cnt"}, {stall_cycles, flush_events}, 64'd0);
        model_clear();
        @(posedge clk);
        halt_id = 0; idex_memread = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
        branch_taken_ex = 0; mem_req = 0; mem_ready = 1;
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_clear();
        @(posedge clk);
        #1;
        apply_reset("rst_init");
        idle("idle");

        // Load-use, non-stalling x0 dependency, branch over load-use; 3 stalls and 2 flushes.
        step("lu", 0, 1, 5, 1, 5, 0, 0, 1);
        idle("lu_after");
        step("lu_x0", 0, 1, 0, 0, 0, 0, 0, 1);
        step("br_lu", 0, 1, 7, 7, 2, 1, 0, 1);
        step("lu2", 0, 1, 3, 3, 0, 0, 0, 1);
        step("lu3", 0, 1, 9, 4, 9, 0, 0, 1);
        step("br2", 0, 0, 0, 0, 0, 1, 0, 1);
        @(negedge clk);
`ifdef PIPELINE_SEQ_PERF_EN
        check("cnt_plan", {stall_cycles, flush_events}, {32'd3, 32'd2});
`else
        check("cnt_plan", {stall_cycles, flush_events}, 64'd0);
`endif
        @(posedge clk);
        #1;

        // Four-cycle memory wait hides a branch until the ready cycle.
        for (int i = 0; i < 4; i++) step("mwait", 1, 0, 0, 0, 0, 1, 1, 0);
        step("mready_br", 0, 0, 0, 0, 0, 1, 1, 1);

        // Halt drains DRAIN cycles, then freezes.
        step("halt", 1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < DRAIN; i++) idle("drain");
        check("halt_lat", 64'(halted), 64'd1);
        for (int i = 0; i < 3; i++) step("frozen", 0, 1, 5, 5, 5, 1, 1, 0);

        // Halt with a two-cycle wait mid-drain.
        apply_reset("rst_a");
        step("halt_w", 1, 0, 0, 0, 0, 0, 0, 1);
        idle("drain_w");
        step("dwait", 0, 0, 0, 0, 0, 0, 1, 0);
        step("dwait", 0, 0, 0, 0, 0, 0, 1, 0);
        idle("drain_w");
        check("halt_w_pre", 64'(halted), 64'd0);
        idle("drain_w");
        check("halt_w_lat", 64'(halted), 64'd1);

        // Reset in the middle of a drain restarts in run.
        apply_reset("rst_b");
        step("halt_r", 1, 0, 0, 0, 0, 0, 0, 1);
        idle("drain_r");
        apply_reset("rst_mid_drain");
        idle("restart");

        // Memory timeout after TMO consecutive wait cycles.
        for (int i = 0; i < TMO; i++) step("tmo_wait", 0, 0, 0, 0, 0, 0, 1, 0);
        check("tmo_err", 64'({mem_err, halted}), 64'd3);
        for (int i = 0; i < 3; i++) idle("tmo_stuck");
        apply_reset("rst_tmo");
        check("tmo_clear", 64'(mem_err), 64'd0);

        // Randomized segments, each started from reset.
        for (int seg = 0; seg < 20; seg++) begin
            for (int i = 0; i < 60; i++) begin
                logic longwait;
                longwait = (seg % 5 == 4);
                step("rnd",
                     ($urandom % 12) == 0,
                     $urandom % 2,
                     5'($urandom % 6),
                     5'($urandom % 6),
                     5'($urandom % 6),
                     ($urandom % 6) == 0,
                     longwait ? 1'b1 : (($urandom % 3) == 0),
                     longwait ? (($urandom % 20) == 0) : (($urandom % 4) != 0));
            end
            apply_reset("rst_rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
